// File: rtl/memory_responder.sv
// Single-port word RAM behind an IDLE/WAIT/DONE handshake that emulates a fixed-latency memory.
// Requests are accepted only in IDLE. Bad addresses and conflicting read+write requests complete with error=1.
module memory_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  LAT_W   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_busy;
  logic        r_error;
  logic [31:0] r_mem [DEPTH];

  logic          w_idle;
  logic          w_accept;
  logic [31:0]   w_cur_addr;
  logic [31:0]   w_cur_wdata;
  logic          w_cur_rd;
  logic          w_cur_wr;
  logic          w_cur_err;
  logic          w_enter_done;
  logic          w_do_read;
  logic          w_do_write;
  logic [AW-1:0] w_idx;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle & (read | write);

  // With LATENCY=0 the access happens on the accepting edge itself, so the live inputs are used then.
  assign w_cur_addr  = w_idle ? addr  : r_addr;
  assign w_cur_wdata = w_idle ? wdata : r_wdata;
  assign w_cur_rd    = w_idle ? read  : r_rd;
  assign w_cur_wr    = w_idle ? write : r_wr;
  assign w_cur_err   = (w_cur_rd & w_cur_wr) | (w_cur_addr >= DEPTH_W);
  assign w_idx       = w_cur_addr[AW-1:0];

  assign w_enter_done = (w_state_next == DONE) & ~clear;
  assign w_do_read    = w_enter_done & w_cur_rd & ~w_cur_err;
  assign w_do_write   = w_enter_done & w_cur_wr & ~w_cur_err;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (read | write) begin
          w_state_next = (LAT_W == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next == DONE);
      r_busy  <= (w_state_next != IDLE);
      r_error <= (w_state_next == DONE) & w_cur_err;
      if (w_accept) begin
        r_cnt <= LAT_W;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do_read) begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

  // Request capture: no reset needed, the fields are only consulted once a request is in flight.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_rd    <= read;
      r_wr    <= write;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_write) begin
      r_mem[w_idx] <= w_cur_wdata;
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign error = r_error;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a LATENCY=2/DEPTH=512 instance and a LATENCY=0/DEPTH=16 instance.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_memory_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear0, read0, write0, ready0, busy0, error0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        clear1, read1, write1, ready1, busy1, error1;
  logic [31:0] addr1, wdata1, rdata1;

  int n_checks = 0;
  int n_errors = 0;
  bit sel = 1'b0;

  memory_responder #(.DEPTH(512), .LATENCY(2)) dut0 (
    .clock(clock), .clear(clear0), .read(read0), .write(write0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .busy(busy0), .error(error0)
  );

  memory_responder #(.DEPTH(16), .LATENCY(0)) dut1 (
    .clock(clock), .clear(clear1), .read(read1), .write(write1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .ready(ready1), .busy(busy1), .error(error1)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      read1 = rd; write1 = wr; addr1 = a; wdata1 = d;
    end else begin
      read0 = rd; write0 = wr; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic sample(output logic rdy, output logic bsy, output logic err, output logic [31:0] rdt);
    rdy = sel ? ready1 : ready0;
    bsy = sel ? busy1  : busy0;
    err = sel ? error1 : error0;
    rdt = sel ? rdata1 : rdata0;
  endtask

  // One request held for exactly the accepting edge, then observed for a bounded 6 cycles.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output int ready_at, output int n_ready, output int n_busy,
                         output logic [31:0] rd_val, output logic err_val);
    logic r, b, e;
    logic [31:0] v;
    drive(rd, wr, a, d);
    tick;
    drive(1'b0, 1'b0, a, d);
    ready_at = -1; n_ready = 0; n_busy = 0; rd_val = 'x; err_val = 1'bx;
    for (int c = 1; c <= 6; c++) begin
      sample(r, b, e, v);
      if (b) n_busy++;
      if (r) begin
        n_ready++;
        if (ready_at < 0) begin
          ready_at = c; rd_val = v; err_val = e;
        end
      end
      tick;
    end
  endtask

  task automatic test_reset;
    clear0 = 1'b1; clear1 = 1'b1;
    sel = 1'b0; drive(1'b1, 1'b0, 32'd5, 32'd0);
    tick; tick;
    n_checks++; if (rdata0 !== 32'd0) begin n_errors++; $display("FAIL reset_rdata0: got %h expected 00000000", rdata0); end
    n_checks++; if (ready0 !== 1'b0) begin n_errors++; $display("FAIL reset_ready0: got %b expected 0", ready0); end
    n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
    n_checks++; if (error0 !== 1'b0) begin n_errors++; $display("FAIL reset_error0: got %b expected 0", error0); end
    n_checks++; if (rdata1 !== 32'd0) begin n_errors++; $display("FAIL reset_rdata1: got %h expected 00000000", rdata1); end
    n_checks++; if (busy1 !== 1'b0) begin n_errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    clear0 = 1'b0; clear1 = 1'b0;
    tick;
  endtask

  task automatic test_write_read;
    int at, nr, nb; logic [31:0] v; logic e;
    sel = 1'b0;
    run_txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, at, nr, nb, v, e);
    n_checks++; if (at != 3) begin n_errors++; $display("FAIL wr_ready_cycle: got %0d expected 3", at); end
    n_checks++; if (nb != 3) begin n_errors++; $display("FAIL wr_busy_cycles: got %0d expected 3", nb); end
    n_checks++; if (nr != 1) begin n_errors++; $display("FAIL wr_ready_count: got %0d expected 1", nr); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL wr_error: got %b expected 0", e); end
    n_checks++; if (v !== 32'd0) begin n_errors++; $display("FAIL wr_rdata_hold: got %h expected 00000000", v); end
    run_txn(1'b1, 1'b0, 32'd5, 32'd0, at, nr, nb, v, e);
    n_checks++; if (at != 3) begin n_errors++; $display("FAIL rd_ready_cycle: got %0d expected 3", at); end
    n_checks++; if (nb != 3) begin n_errors++; $display("FAIL rd_busy_cycles: got %0d expected 3", nb); end
    n_checks++; if (v !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_data: got %h expected deadbeef", v); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL rd_error: got %b expected 0", e); end
  endtask

  task automatic test_bad_address;
    int at, nr, nb; logic [31:0] v; logic e;
    sel = 1'b0;
    run_txn(1'b1, 1'b0, 32'd512, 32'd0, at, nr, nb, v, e);
    n_checks++; if (at != 3) begin n_errors++; $display("FAIL bad512_ready_cycle: got %0d expected 3", at); end
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL bad512_error: got %b expected 1", e); end
    n_checks++; if (v !== 32'hDEADBEEF) begin n_errors++; $display("FAIL bad512_rdata_hold: got %h expected deadbeef", v); end
    run_txn(1'b1, 1'b0, 32'hFFFF0005, 32'd0, at, nr, nb, v, e);
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL badhigh_error: got %b expected 1", e); end
    n_checks++; if (v !== 32'hDEADBEEF) begin n_errors++; $display("FAIL badhigh_rdata_hold: got %h expected deadbeef", v); end
    run_txn(1'b0, 1'b1, 32'hFFFF0005, 32'h99999999, at, nr, nb, v, e);
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL badwrite_error: got %b expected 1", e); end
    run_txn(1'b0, 1'b1, 32'd511, 32'h0BADCAFE, at, nr, nb, v, e);
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL wr511_error: got %b expected 0", e); end
    run_txn(1'b1, 1'b0, 32'd511, 32'd0, at, nr, nb, v, e);
    n_checks++; if (v !== 32'h0BADCAFE) begin n_errors++; $display("FAIL rd511_data: got %h expected 0badcafe", v); end
    run_txn(1'b1, 1'b0, 32'd5, 32'd0, at, nr, nb, v, e);
    n_checks++; if (v !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd5_after_errors: got %h expected deadbeef", v); end
  endtask

  task automatic test_rw_conflict;
    int at, nr, nb; logic [31:0] v; logic e;
    sel = 1'b0;
    run_txn(1'b0, 1'b1, 32'd7, 32'h11111111, at, nr, nb, v, e);
    run_txn(1'b1, 1'b1, 32'd7, 32'h00000001, at, nr, nb, v, e);
    n_checks++; if (at != 3) begin n_errors++; $display("FAIL rw_ready_cycle: got %0d expected 3", at); end
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL rw_error: got %b expected 1", e); end
    n_checks++; if (v !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rw_rdata_hold: got %h expected deadbeef", v); end
    run_txn(1'b1, 1'b0, 32'd7, 32'd0, at, nr, nb, v, e);
    n_checks++; if (v !== 32'h11111111) begin n_errors++; $display("FAIL rw_ram_untouched: got %h expected 11111111", v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rmask, bmask, first_v;
    logic r, b, e;
    logic [31:0] v;
    sel = 1'b0;
    rmask = '0; bmask = '0; first_v = '0;
    drive(1'b1, 1'b0, 32'd5, 32'd0);
    for (int c = 1; c <= 16; c++) begin
      tick;
      sample(r, b, e, v);
      rmask[c] = r;
      bmask[c] = b;
      if (c == 3) first_v = v;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick; tick;
    n_checks++; if (rmask !== 32'h00008888) begin n_errors++; $display("FAIL b2b_ready_pattern: got %h expected 00008888", rmask); end
    n_checks++; if (bmask !== 32'h0000EEEE) begin n_errors++; $display("FAIL b2b_busy_pattern: got %h expected 0000eeee", bmask); end
    n_checks++; if (first_v !== 32'hDEADBEEF) begin n_errors++; $display("FAIL b2b_rdata: got %h expected deadbeef", first_v); end
  endtask

  task automatic test_input_change;
    int at, nr, nb; logic [31:0] v; logic e;
    sel = 1'b0;
    drive(1'b1, 1'b0, 32'd5, 32'd0);
    tick;
    drive(1'b0, 1'b1, 32'd7, 32'h0);
    tick; tick;
    n_checks++; if (ready0 !== 1'b1) begin n_errors++; $display("FAIL chg_ready: got %b expected 1", ready0); end
    n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL chg_rdata: got %h expected deadbeef", rdata0); end
    n_checks++; if (error0 !== 1'b0) begin n_errors++; $display("FAIL chg_error: got %b expected 0", error0); end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick; tick;
    run_txn(1'b1, 1'b0, 32'd7, 32'd0, at, nr, nb, v, e);
    n_checks++; if (v !== 32'h11111111) begin n_errors++; $display("FAIL chg_no_write: got %h expected 11111111", v); end
  endtask

  task automatic test_clear_abort;
    int at, nr, nb, late_ready; logic [31:0] v; logic e;
    sel = 1'b0;
    run_txn(1'b0, 1'b1, 32'd9, 32'hCAFEF00D, at, nr, nb, v, e);
    drive(1'b0, 1'b1, 32'd9, 32'h12345678);
    tick;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    clear0 = 1'b1;
    tick;
    clear0 = 1'b0;
    n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", busy0); end
    n_checks++; if (ready0 !== 1'b0) begin n_errors++; $display("FAIL abort_ready: got %b expected 0", ready0); end
    n_checks++; if (rdata0 !== 32'd0) begin n_errors++; $display("FAIL abort_rdata: got %h expected 00000000", rdata0); end
    late_ready = 0;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (ready0) late_ready++;
    end
    n_checks++; if (late_ready != 0) begin n_errors++; $display("FAIL abort_late_ready: got %0d pulses expected 0", late_ready); end
    run_txn(1'b1, 1'b0, 32'd9, 32'd0, at, nr, nb, v, e);
    n_checks++; if (v !== 32'hCAFEF00D) begin n_errors++; $display("FAIL abort_no_write: got %h expected cafef00d", v); end
  endtask

  task automatic test_latency0;
    int at, nr, nb; logic [31:0] v; logic e;
    sel = 1'b1;
    run_txn(1'b0, 1'b1, 32'd0, 32'hA5A5A5A5, at, nr, nb, v, e);
    n_checks++; if (at != 1) begin n_errors++; $display("FAIL l0_wr_ready_cycle: got %0d expected 1", at); end
    n_checks++; if (nb != 1) begin n_errors++; $display("FAIL l0_wr_busy_cycles: got %0d expected 1", nb); end
    run_txn(1'b1, 1'b0, 32'd0, 32'd0, at, nr, nb, v, e);
    n_checks++; if (at != 1) begin n_errors++; $display("FAIL l0_rd_ready_cycle: got %0d expected 1", at); end
    n_checks++; if (v !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL l0_rd_data: got %h expected a5a5a5a5", v); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL l0_rd_error: got %b expected 0", e); end
    run_txn(1'b1, 1'b0, 32'd16, 32'd0, at, nr, nb, v, e);
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL l0_bad_error: got %b expected 1", e); end
    n_checks++; if (v !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL l0_bad_rdata_hold: got %h expected a5a5a5a5", v); end
  endtask

  initial begin
    clear0 = 1'b0; read0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    clear1 = 1'b0; read1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset;
    test_write_read;
    test_bad_address;
    test_rw_conflict;
    test_back_to_back;
    test_input_change;
    test_clear_abort;
    test_latency0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, number of 32-bit words in the internal RAM (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port read  input  1  read request, sampled only in IDLE.
REQ-006 SHALL have port write  input  1  write request, sampled only in IDLE.
REQ-007 SHALL have port addr  input  32  word address, driven from the CPU memory address register.
REQ-008 SHALL have port wdata  input  32  write data, driven from the CPU memory data register.
REQ-009 SHALL have port rdata  output  32  read data, feeds the CPU memory data register input.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  transaction in progress.
REQ-012 SHALL have port error  output  1  completion status, valid only while ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE; all outputs registered.
REQ-014 In IDLE, (read|write)=1 at an edge SHALL accept the request: capture addr, wdata, op; load wait counter with LATENCY; go to WAIT, or to DONE directly if LATENCY=0.
REQ-015 In WAIT, the counter SHALL decrement each cycle; on the edge where it reaches zero, go to DONE.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 ready SHALL be 1 only in DONE, exactly LATENCY+1 cycles after the accepting edge.
REQ-018 busy SHALL be 1 in WAIT and DONE, 0 in IDLE.
REQ-019 read/write while busy=1 SHALL be ignored; no queueing, no effect on the transaction in flight.
REQ-020 Maximum throughput SHALL be one transaction per LATENCY+2 cycles.
REQ-021 Addressing SHALL use captured addr as a word index; address valid iff addr < DEPTH (full 32-bit compare, no wrap-around).
REQ-022 Valid read: rdata SHALL be loaded with RAM[addr] on the edge entering DONE; error=0.
REQ-023 Valid write: RAM[addr] SHALL be written with captured wdata on the edge entering DONE; rdata unchanged; error=0.
REQ-024 Invalid address, or read=1 and write=1 together at acceptance, SHALL complete with normal timing and error=1, no RAM write, rdata unchanged.
REQ-025 rdata SHALL hold its value between reads, including across writes and errors.
REQ-026 Inputs changing after acceptance SHALL NOT affect the transaction.
REQ-027 A read of an address in the same transaction window after a completed write SHALL return the written data (write visible from the cycle after ready).

Reset
REQ-028 clear=1 at an edge SHALL force state IDLE, counter 0, rdata=0, ready=0, busy=0, error=0; clear has priority over all requests.
REQ-029 clear mid-transaction SHALL abort it: no ready pulse, no RAM write.
REQ-030 RAM contents SHALL NOT be altered by clear; uninitialised contents are don't-care for verification.

Verification
REQ-031 LATENCY=2: write addr=5 wdata=0xDEADBEEF, then read addr=5 -> each ready pulses 3 cycles after accept, busy high 3 cycles; rdata=0xDEADBEEF, error=0.
REQ-032 Read addr=512 (DEPTH=512) and addr=0xFFFF0005 -> ready with error=1, rdata keeps previous 0xDEADBEEF; RAM[5] unchanged.
REQ-033 read=1 write=1 same cycle addr=7 wdata=0x1 -> error=1; subsequent read addr=7 returns prior content, not 0x1.
REQ-034 Hold read=1 continuously addr=5 -> exactly one ready per 4 cycles; requests during busy produce no extra ready.
REQ-035 Write addr=9 wdata=0x12345678, assert clear one cycle after accept -> no ready, busy=0, rdata=0; later read addr=9 does not return 0x12345678 unless previously written.
REQ-036 LATENCY=0 build: write then read addr=0 value 0xA5A5A5A5 -> ready cycle immediately after each accept, rdata=0xA5A5A5A5.
